// File: rtl/resp_router.sv
// Read-response router: records the owner of every accepted read and steers each
// BURST_LEN-beat response to the icache or dcache that issued it, in issue order.
module resp_router #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BURST_LEN      = 8,
  parameter int DEPTH          = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic                      bus_reqack,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      req_src,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack,
  output logic                      ic_respcyc,
  output logic                      dc_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] ic_resp,
  output logic [BUS_DATA_WIDTH-1:0] dc_resp,
  output logic [BUS_TAG_WIDTH-1:0]  ic_resptag,
  output logic [BUS_TAG_WIDTH-1:0]  dc_resptag,
  input  logic                      ic_respack,
  input  logic                      dc_respack,
  output logic                      fifo_full,
  output logic                      err
);

  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(DEPTH + 1);
  localparam int EW = BUS_TAG_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t                   state;
  logic [CW-1:0]            cnt;
  logic [EW-1:0]            mem [DEPTH];
  logic [PW-1:0]            rd_ptr, wr_ptr;
  logic [NW-1:0]            count;
  logic                     empty, full, push, push_ok, pop, route, xfer, last, head_src;
  logic [BUS_TAG_WIDTH-1:0] head_tag;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (count == '0);
  assign full      = (count == NW'(DEPTH));
  assign fifo_full = full;
  assign {head_src, head_tag} = mem[rd_ptr];
  assign push      = bus_reqcyc & bus_reqack & bus_reqtag[BUS_TAG_WIDTH-1];
  assign push_ok   = push & ~full;
  assign route     = reset & ((state == BURST) | ((state == IDLE) & ~empty));
  assign xfer      = bus_respcyc & bus_respack;
  // cnt is 0 in IDLE, so this also covers a single-beat burst completing there
  assign last      = (cnt == CW'(BURST_LEN - 1));
  assign pop       = route & xfer & last;

  always_comb begin
    bus_respack = 1'b0;
    ic_respcyc  = 1'b0;
    dc_respcyc  = 1'b0;
    ic_resp     = '0;
    dc_resp     = '0;
    ic_resptag  = '0;
    dc_resptag  = '0;
    if (route) begin
      if (head_src) begin
        dc_respcyc  = bus_respcyc;
        dc_resp     = bus_resp;
        dc_resptag  = bus_resptag;
        bus_respack = dc_respack;
      end else begin
        ic_respcyc  = bus_respcyc;
        ic_resp     = bus_resp;
        ic_resptag  = bus_resptag;
        bus_respack = ic_respack;
      end
    end else if (reset) begin
      // orphan responses are swallowed so the bus never stalls
      bus_respack = bus_respcyc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
      mem    <= '{default: '0};
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= {req_src, bus_reqtag};
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (pop && !push_ok) count <= count - 1'b1;
      if (push && full) err <= 1'b1;

      unique case (state)
        IDLE: begin
          if (bus_respcyc && empty) begin
            err   <= 1'b1;
            state <= last ? IDLE : DRAIN;
            cnt   <= last ? '0 : CW'(1);
          end else if (xfer && !empty) begin
            if (bus_resptag != head_tag) err <= 1'b1;
            if (!last) begin
              state <= BURST;
              cnt   <= CW'(1);
            end
          end
        end
        BURST, DRAIN: begin
          if (xfer) begin
            if (last) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/resp_router.md
RESP_ROUTER -- requirements
Module: resp_router

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- BUS_DATA_WIDTH, 64, response beat width.
- BUS_TAG_WIDTH, 13, request/response tag width; bit [BUS_TAG_WIDTH-1]=1 marks a read.
- BURST_LEN, 8, beats per read response.
- DEPTH, 4, outstanding-read owner FIFO entries.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state on rising edge.
- reset, in, 1, asynchronous, active-low reset.
- bus_reqcyc, in, 1, arbiter request valid, snooped.
- bus_reqack, in, 1, memory accepted request, snooped.
- bus_reqtag, in, BUS_TAG_WIDTH, snooped request tag.
- req_src, in, 1, owner of the current request: 0=icache, 1=dcache.
- bus_respcyc, in, 1, response beat valid.
- bus_resp, in, BUS_DATA_WIDTH, response beat data.
- bus_resptag, in, BUS_TAG_WIDTH, response tag.
- bus_respack, out, 1, beat consumed.
- ic_respcyc / dc_respcyc, out, 1, beat valid to icache / dcache.
- ic_resp / dc_resp, out, BUS_DATA_WIDTH, beat data.
- ic_resptag / dc_resptag, out, BUS_TAG_WIDTH, beat tag.
- ic_respack / dc_respack, in, 1, cache consumed beat.
- fifo_full, out, 1, owner FIFO holds DEPTH entries.
- err, out, 1, sticky protocol error.

Function
REQ-003 Push SHALL happen on a clock edge where bus_reqcyc=1, bus_reqack=1 and bus_reqtag[BUS_TAG_WIDTH-1]=1; entry = {req_src, bus_reqtag}. Writes SHALL NOT be pushed.
REQ-004 A push while full SHALL be dropped and SHALL set err; FIFO contents SHALL be unchanged.
REQ-005 States SHALL be IDLE, BURST, DRAIN; beat counter SHALL be ceil(log2(BURST_LEN)) bits.
REQ-006 A beat is transferred when bus_respcyc=1 and bus_respack=1.
REQ-007 IDLE, FIFO non-empty, bus_respcyc=1: route combinationally to the head owner in the same cycle (zero latency); next state BURST; counter=1 if the beat transfers, else stay IDLE.
REQ-008 IDLE, FIFO empty, bus_respcyc=1: set err, assert bus_respack, next state DRAIN with counter=1; no cache respcyc asserted.
REQ-009 Routing SHALL use head owner: owner's respcyc=bus_respcyc, resp/resptag=bus_resp/bus_resptag, bus_respack=owner's respack; the non-owner's respcyc=0, resp=0, resptag=0.
REQ-010 BURST: counter increments per transferred beat; on beat BURST_LEN pop the FIFO and return to IDLE.
REQ-011 DRAIN: bus_respack=bus_respcyc; after BURST_LEN beats return to IDLE; no pop.
REQ-012 First beat's bus_resptag differing from head tag SHALL set err; routing still follows the head owner.
REQ-013 Simultaneous push and pop SHALL leave the count unchanged and write the entry behind the new head. A push into an empty FIFO SHALL be routable no earlier than the next cycle.
REQ-014 Pointers SHALL wrap modulo DEPTH; fifo_full = (count==DEPTH).
REQ-015 bus_respcyc=0 mid-burst SHALL hold state and counter.

Reset
REQ-016 reset=0 SHALL immediately clear FIFO, pointers, count, counter and err, and force state IDLE, including mid-burst.
REQ-017 During reset, all outputs SHALL be 0: bus_respack, ic_respcyc, dc_respcyc, resp and resptag buses, fifo_full and err.

Verification
REQ-018 Scenario: icache read with tag 0x1040 accepted, then 8 beats 0x0..0x7 with ic_respack=1 -> ic_respcyc high for 8 cycles with data 0..7; dc_respcyc=0; FIFO empty after the last beat.
REQ-019 Scenario: dcache read 0x1080, then icache read 0x10C0 -> first 8 beats go to dcache, next 8 beats go to icache, in order.
REQ-020 Scenario: dc_respack held 0 for 3 cycles at beat 4 -> bus_respack=0 for those cycles; counter holds at 4; no beat lost.
REQ-021 Scenario: 5 reads pushed with DEPTH=4 -> fifo_full=1 after the 4th; 5th dropped; err=1.
REQ-022 Scenario: response with empty FIFO -> err=1; 8 beats acked; no cache respcyc asserted; state returns to IDLE.
REQ-023 Scenario: reset asserted at beat 3 of a burst -> all outputs 0 at once; after release, a new read/response completes normally.
